// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle unsigned multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply or restoring divide over XLEN iterations; the
// result is registered and announced with a one-cycle done pulse.
//
// Ports
//   clk_i     rising-edge clock
//   rst_ni    asynchronous active-low reset
//   start_i   operation request, sampled only in IDLE
//   op_i      00 MUL, 01 MULHU, 10 DIVU, 11 REMU (all unsigned)
//   a_i/b_i   multiplicand/dividend and multiplier/divisor
//   flush_i   synchronous abort back to IDLE, wins over start
//   busy_o    unit is not idle
//   stall_o   holds the pipeline until the result is delivered
//   done_o    one-cycle pulse, result_o valid
//   result_o  registered result, holds until the next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add / shift-subtract iteration per cycle
// DONE  | result valid, done pulse, back to IDLE next cycle
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;   // product high half / partial remainder
  logic [XLEN-1:0] sh_q;    // product low half / quotient shift register
  logic [XLEN-1:0] result_q;
  logic            busy_q;
  logic            done_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_t;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] sh_d;
  logic [XLEN-1:0] res_d;

  // One iteration of either datapath; both share the XLEN+1 bit width so the
  // multiply carry lands in the top bit of hi after the shift.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    div_t    = {acc_q, sh_q[XLEN-1]};
    div_ge   = (div_t >= {1'b0, b_q});
    // When div_ge holds the difference is below b, so XLEN bits suffice.
    div_diff = div_t[XLEN-1:0] - b_q;
    if (op_q[1]) begin
      acc_d = div_ge ? div_diff : div_t[XLEN-1:0];
      sh_d  = {sh_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      sh_d  = {mul_sum[0], sh_q[XLEN-1:1]};
    end
    // MUL/DIVU take the shift register (lo/quo), MULHU/REMU the accumulator.
    res_d = op_q[0] ? acc_d : sh_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q   <= op_i;
            b_q    <= b_i;
            acc_q  <= '0;
            sh_q   <= a_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (op_i[1] && (b_i == '0)) begin
              // RISC-V divide-by-zero: quotient all ones, remainder = dividend
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= op_i[0] ? a_i : '1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            if (cnt_q == CW'(XLEN - 1)) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= res_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign stall_o  = (start_i && (state_q == S_IDLE)) || (busy_q && !done_q);

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle integer multiply/divide unit for the execute stage. It accepts one operation from the pipeline, sequences a radix-2 shift-add multiply or restoring divide over XLEN iterations, and returns a registered result with a one-cycle done pulse. While it works, it drives a stall to the hazard unit. It is the scheduling companion to the single-cycle ALU and owns its own XLEN+1-bit adder/subtractor.

## Interface
- XLEN, 32: operand/result width; iteration count equals XLEN.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL (low XLEN of product), 01 MULHU (high XLEN), 10 DIVU (quotient), 11 REMU (remainder); all unsigned.
- a  input  XLEN  multiplicand / dividend, captured with start.
- b  input  XLEN  multiplier / divisor, captured with start.
- flush  input  1  synchronous abort from pipeline flush.
- busy  output  1  state != IDLE.
- stall  output  1  start&IDLE | (busy & ~done); holds the pipeline until the result is delivered.
- done  output  1  single-cycle pulse; result valid.
- result  output  XLEN  registered result; holds until the next done.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0: capture op, a, b; clear count.
  - Divide with b==0: go to DONE directly. result = all ones (DIVU) or a (REMU), per RISC-V.
  - Otherwise go to RUN.
- Multiply datapath: product register {hi, lo}, with lo=a and hi=0. Each RUN cycle: {c, s} = hi + (lo[0] ? b : 0) on XLEN+1 bits; then {hi, lo} <= {c, s, lo} >> 1.
- Divide datapath: rem=0, quo=a. Each RUN cycle: t = {rem, quo[XLEN-1]} on XLEN+1 bits. If t >= {0, b}, then rem <= t - b and shift in quotient bit 1. Else rem <= t[XLEN-1:0] and shift in 0. quo shifts left.
- count increments every RUN cycle. When count==XLEN-1, go to DONE. The result register loads the selected field: lo, hi, quo or rem.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start in RUN or DONE is ignored. No queueing; the pipeline holds start until done.
- flush=1 in any state: go to IDLE on the next edge, with no done pulse and result unchanged. flush wins over a simultaneous start.
- Reset: state=IDLE, count=0, result=0, internal registers 0, busy=0, stall=0, done=0.
- Reset asserted mid-operation: abort immediately and asynchronously. No done is produced.

## Timing
- Start is sampled at edge E0, in cycle 0.
- Normal operation: RUN for cycles 1..XLEN. done=1 and result valid in cycle XLEN+1 (33 for XLEN=32). Back in IDLE in cycle XLEN+2.
- Earliest next accepted start: in cycle XLEN+2. Throughput is one operation per XLEN+2 cycles.
- Divide by zero: done in cycle 1, latency 1.
- busy is high from cycle 1 through the done cycle inclusive.
- stall is high in cycle 0, through cycle XLEN, and low in the done cycle. The consuming stage takes result in the done cycle.
- result changes only at the edge entering DONE.
- count is $clog2(XLEN) bits wide. Compare against XLEN-1 exactly; no wrap past XLEN-1.
- All outputs are registered or decoded from state only. They have no combinational path from a, b or op.

## Test plan
- MUL a=0x0000_1234, b=0x0000_5678 -> done at cycle 33, result=0x0626_0060. MULHU same operands -> result=0x0000_0000.
- MULHU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result=0xFFFF_FFFE. MUL same operands -> result=0x0000_0001. This checks the carry into hi.
- DIVU a=100, b=7 -> result=14 at cycle 33. REMU -> result=2. DIVU a=0xFFFF_FFFF, b=1 -> result=0xFFFF_FFFF.
- DIVU a=5, b=0 -> done in cycle 1, result=0xFFFF_FFFF. REMU a=5, b=0 -> result=5. stall is high in cycle 0 only.
- Flush at cycle 10 of a DIVU -> IDLE at cycle 11, no done, result keeps its prior value. Start held during RUN is ignored. A new start in cycle 11 completes normally in cycle 44.
- Drop rst at cycle 15 of a MUL -> busy, stall and done go to 0 asynchronously and result=0. After release, a new MUL completes correctly.
